// File: rtl/crack_scheduler.sv
// crack_scheduler: deals first-character chunks to idle crackers, aborts all on the first hit and reports the password
module crack_scheduler #(
    parameter int NUM_WORKERS  = 4,
    parameter int CHARSET_SIZE = 36,
    parameter int IDX_W        = 6,
    parameter int CHUNK        = 4,
    parameter int PW_BITS      = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [PW_BITS-1:0]             target_pw,
    output logic                           busy,
    output logic                           done,
    output logic                           found,
    output logic [PW_BITS-1:0]             found_pw,
    output logic [NUM_WORKERS-1:0]         worker_start,
    output logic [IDX_W-1:0]               worker_from,
    output logic [IDX_W-1:0]               worker_to,
    output logic [PW_BITS-1:0]             worker_target,
    output logic                           worker_abort,
    input  logic [NUM_WORKERS-1:0]         worker_done,
    input  logic [NUM_WORKERS-1:0]         worker_found,
    input  logic [NUM_WORKERS*PW_BITS-1:0] worker_pw
);
    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(CHARSET_SIZE - 1);
    localparam logic [IDX_W:0] STEP = (IDX_W+1)'(CHUNK);
    localparam logic [IDX_W:0] SPAN = (IDX_W+1)'(CHUNK - 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT, S_DONE} state_t;
    state_t                 r_state;
    logic [IDX_W:0]         r_next;
    logic [NUM_WORKERS-1:0] r_mask;
    logic [NUM_WORKERS-1:0] w_hit;
    logic [NUM_WORKERS-1:0] w_hit_oh;
    logic [NUM_WORKERS-1:0] w_free;
    logic [NUM_WORKERS-1:0] w_free_oh;
    logic [NUM_WORKERS-1:0] w_mask_nd;
    logic [PW_BITS-1:0]     w_hit_pw;
    logic [IDX_W:0]         w_end;
    logic                   w_more;
    always_comb begin
        w_hit     = worker_found & r_mask;
        w_hit_oh  = w_hit & (~w_hit + NUM_WORKERS'(1));
        w_free    = ~r_mask;
        w_free_oh = w_free & (r_mask + NUM_WORKERS'(1));
        w_mask_nd = r_mask & ~worker_done;
        w_more    = r_next <= LAST;
        w_end     = (r_next + SPAN > LAST) ? LAST : r_next + SPAN;
        w_hit_pw  = '0;
        for (int i = 0; i < NUM_WORKERS; i++)
            w_hit_pw = w_hit_oh[i] ? worker_pw[i*PW_BITS +: PW_BITS] : w_hit_pw;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_next        <= '0;
            r_mask        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            found_pw      <= '0;
            worker_start  <= '0;
            worker_from   <= '0;
            worker_to     <= '0;
            worker_target <= '0;
            worker_abort  <= 1'b0;
        end else begin
            worker_start <= '0;
            worker_abort <= 1'b0;
            done         <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    worker_target <= target_pw;
                    r_next        <= '0;
                    r_mask        <= '0;
                    found         <= 1'b0;
                    found_pw      <= '0;
                    busy          <= 1'b1;
                    r_state       <= S_RUN;
                end
                S_RUN: if (|w_hit) begin
                    found        <= 1'b1;
                    found_pw     <= w_hit_pw;
                    worker_abort <= 1'b1;
                    r_state      <= S_ABORT;
                end else if (w_more && |w_free) begin
                    worker_start <= w_free_oh;
                    worker_from  <= r_next[IDX_W-1:0];
                    worker_to    <= w_end[IDX_W-1:0];
                    r_mask       <= w_mask_nd | w_free_oh;
                    r_next       <= r_next + STEP;
                end else begin
                    r_mask <= w_mask_nd;
                    if (!w_more && w_mask_nd == '0) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_ABORT: begin
                    r_mask  <= '0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
